led7seg_scan_controller: RTL and testbench

- Time-multiplexes a DIGITS-wide hex value onto one shared 4-bit-to-7-segment decoder and a common-segment LED array.
- Holds the value to display and presents one nibble at a time on `number`, which feeds the decoder.
- Drives a one-hot digit-select and inserts a blanking gap between digits to prevent ghosting.
- New values are accepted through a valid/ready handshake and applied only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/led7seg_scan_controller.sv | 194 +++++++++++++++++++
 tb/tb_led7seg_scan_controller.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led7seg_scan_controller.sv
// Multiplexed 7-segment scan controller.
// A DIGITS-wide hex value is shown one digit at a time, with a blanking gap before each digit.
module led7seg_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int DWELL        = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  lz_blank,
  input  logic                  wr_valid,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic [DIGITS-1:0]     wr_dp,
  output logic                  wr_ready,
  output logic [3:0]            number,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  seg_blank,
  output logic                  frame_done
);

  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CMAX = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;

  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LOAD = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_ONE = DIGITS'(1);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [4*DIGITS-1:0]   disp_data_reg, disp_data_next;
  logic [DIGITS-1:0]     disp_dp_reg, disp_dp_next;
  logic [4*DIGITS-1:0]   pend_data_reg, pend_data_next;
  logic [DIGITS-1:0]     pend_dp_reg, pend_dp_next;
  logic                  pend_flag_reg, pend_flag_next;

  logic                  transfer;
  logic                  commit;

  logic                  wr_ready_next;
  logic [3:0]            number_next;
  logic                  dp_next;
  logic [DIGITS-1:0]     digit_sel_next;
  logic                  seg_blank_next;
  logic                  frame_done_next;

  logic [3:0]            disp_nib [DIGITS];
  logic [DIGITS-1:0]     digit_empty;
  logic [DIGITS-1:0]     lead_zero;
  logic                  suppress;

  // State register: every output is a register loaded from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= OFF;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      disp_data_reg <= '0;
      disp_dp_reg   <= '0;
      pend_data_reg <= '0;
      pend_dp_reg   <= '0;
      pend_flag_reg <= 1'b0;
      wr_ready      <= 1'b1;
      number        <= 4'd0;
      dp            <= 1'b0;
      digit_sel     <= '0;
      seg_blank     <= 1'b1;
      frame_done    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      cnt_reg       <= cnt_next;
      disp_data_reg <= disp_data_next;
      disp_dp_reg   <= disp_dp_next;
      pend_data_reg <= pend_data_next;
      pend_dp_reg   <= pend_dp_next;
      pend_flag_reg <= pend_flag_next;
      wr_ready      <= wr_ready_next;
      number        <= number_next;
      dp            <= dp_next;
      digit_sel     <= digit_sel_next;
      seg_blank     <= seg_blank_next;
      frame_done    <= frame_done_next;
    end
  end

  // Next-state: scan timing plus the pending/display buffer handoff.
  always_comb begin : next_state_logic
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;

    if (!enable) begin
      state_next = OFF;
      idx_next   = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        OFF: begin
          idx_next = '0;
          if (BLANK_CYCLES == 0) begin
            state_next = SHOW;
            cnt_next   = DWELL_LOAD;
          end else begin
            state_next = BLANK;
            cnt_next   = BLANK_LOAD;
          end
        end
        BLANK: begin
          if (cnt_reg == '0) begin
            state_next = SHOW;
            cnt_next   = DWELL_LOAD;
          end else begin
            cnt_next = cnt_reg - CNT_ONE;
          end
        end
        SHOW: begin
          if (cnt_reg == '0) begin
            idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_ONE;
            if (BLANK_CYCLES == 0) begin
              state_next = SHOW;
              cnt_next   = DWELL_LOAD;
            end else begin
              state_next = BLANK;
              cnt_next   = BLANK_LOAD;
            end
          end else begin
            cnt_next = cnt_reg - CNT_ONE;
          end
        end
        default: begin
          state_next = OFF;
          idx_next   = '0;
          cnt_next   = '0;
        end
      endcase
    end

    // frame_done marks the last cycle of a frame, so a commit there lands on the next frame's first digit.
    transfer       = wr_valid && wr_ready;
    commit         = pend_flag_reg && (!enable || frame_done);
    disp_data_next = commit ? pend_data_reg : disp_data_reg;
    disp_dp_next   = commit ? pend_dp_reg : disp_dp_reg;
    pend_data_next = transfer ? wr_data : pend_data_reg;
    pend_dp_next   = transfer ? wr_dp : pend_dp_reg;
    pend_flag_next = transfer || (pend_flag_reg && !commit);
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign disp_nib[gi]    = disp_data_next[4*gi +: 4];
      assign digit_empty[gi] = (disp_data_next[4*gi +: 4] == 4'd0) && !disp_dp_next[gi];
    end
  endgenerate

  // lead_zero[i]: every digit from the top down to i is blank (zero nibble, no dp).
  always_comb begin : lead_zero_scan
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run          = run && digit_empty[i];
      lead_zero[i] = run;
    end
  end

  always_comb begin : output_logic
    suppress        = lz_blank && (idx_next != '0) && lead_zero[idx_next];
    wr_ready_next   = !pend_flag_next;
    number_next     = disp_nib[idx_next];
    dp_next         = disp_dp_next[idx_next];
    digit_sel_next  = '0;
    seg_blank_next  = 1'b1;
    frame_done_next = (state_next == SHOW) && (idx_next == LAST_IDX) && (cnt_next == '0);
    if (state_next == SHOW && !suppress) begin
      digit_sel_next = SEL_ONE << idx_next;
      seg_blank_next = 1'b0;
    end
  end

endmodule

// File: tb/tb_led7seg_scan_controller.sv
// Bench for led7seg_scan_controller: two builds (with and without blanking gap) share the stimulus,
// a frame-position reference model fills a queue and a negedge monitor compares every cycle.
module tb_led7seg_scan_controller;
  localparam int DIGITS = 4;
  localparam int DWELL  = 4;
  localparam int BL     = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        lz_blank = 1'b0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = 16'h0;
  logic [3:0]  wr_dp = 4'h0;

  logic       rdy_a, dp_a, sb_a, fd_a;
  logic [3:0] num_a, sel_a;
  logic       rdy_b, dp_b, sb_b, fd_b;
  logic [3:0] num_b, sel_b;

  always #5 clk = ~clk;

  led7seg_scan_controller #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK_CYCLES(BL)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lz_blank(lz_blank),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_dp(wr_dp), .wr_ready(rdy_a),
    .number(num_a), .dp(dp_a), .digit_sel(sel_a), .seg_blank(sb_a), .frame_done(fd_a));

  led7seg_scan_controller #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lz_blank(lz_blank),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_dp(wr_dp), .wr_ready(rdy_b),
    .number(num_b), .dp(dp_b), .digit_sel(sel_b), .seg_blank(sb_b), .frame_done(fd_b));

  typedef struct packed {
    logic       rdy;
    logic [3:0] num;
    logic       dp;
    logic [3:0] sel;
    logic       sb;
    logic       fd;
  } out_t;

  typedef struct packed {
    out_t a;
    out_t b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference state: frame position p (-1 = dark), display and pending buffers.
  int          m_p   [2];
  logic [15:0] m_disp[2];
  logic [3:0]  m_ddp [2];
  logic [15:0] m_pend[2];
  logic [3:0]  m_pdp [2];
  logic        m_pf  [2];
  logic        m_lz;

  function automatic out_t model_out(input int k, input int bl);
    out_t o;
    int   slot_len, period, idx, lead;
    logic show, fd, supp;
    slot_len = DWELL + bl;
    period   = DIGITS * slot_len;
    idx = 0; show = 1'b0; fd = 1'b0;
    if (m_p[k] >= 0) begin
      idx  = m_p[k] / slot_len;
      show = (m_p[k] % slot_len) >= bl;
      fd   = (m_p[k] == period - 1);
    end
    lead = -1;
    for (int i = 0; i < DIGITS; i++)
      if (m_disp[k][4*i +: 4] != 4'h0 || m_ddp[k][i]) lead = i;
    supp  = m_lz && idx > 0 && idx > lead;
    o.rdy = !m_pf[k];
    o.num = m_disp[k][4*idx +: 4];
    o.dp  = m_ddp[k][idx];
    o.sel = (show && !supp) ? (4'b0001 << idx) : 4'b0000;
    o.sb  = !(show && !supp);
    o.fd  = fd;
    return o;
  endfunction

  task automatic model_step(input int k, input int bl);
    int   period;
    logic fd_now, commit, xfer;
    period = DIGITS * (DWELL + bl);
    fd_now = (m_p[k] == period - 1);
    commit = m_pf[k] && (!enable || fd_now);
    xfer   = wr_valid && !m_pf[k];
    if (commit) begin
      m_disp[k] = m_pend[k];
      m_ddp[k]  = m_pdp[k];
    end
    if (xfer) begin
      m_pend[k] = wr_data;
      m_pdp[k]  = wr_dp;
      m_pf[k]   = 1'b1;
    end else if (commit) begin
      m_pf[k] = 1'b0;
    end
    if (!enable) m_p[k] = -1;
    else if (m_p[k] < 0) m_p[k] = 0;
    else m_p[k] = (m_p[k] + 1) % period;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_p[k] = -1; m_disp[k] = '0; m_ddp[k] = '0;
      m_pend[k] = '0; m_pdp[k] = '0; m_pf[k] = 1'b0;
    end
    m_lz = 1'b0;
  endtask

  // Stimulus side: predict each cycle's outputs and queue them.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        exp_q.delete();
      end else begin
        model_step(0, BL);
        model_step(1, 0);
        m_lz = lz_blank;
      end
      exp_q.push_back({model_out(0, BL), model_out(1, 0)});
    end
  end

  // Monitor side: pop one prediction per cycle and compare both builds.
  initial begin
    exp_t e;
    out_t got_a, got_b;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got_a = {rdy_a, num_a, dp_a, sel_a, sb_a, fd_a};
        got_b = {rdy_b, num_b, dp_b, sel_b, sb_b, fd_b};
        checks++;
        if (got_a !== e.a) begin
          failures++;
          $display("FAIL scan_blank2 t=%0t got rdy=%b num=%h dp=%b sel=%b sb=%b fd=%b expected rdy=%b num=%h dp=%b sel=%b sb=%b fd=%b",
                   $time, got_a.rdy, got_a.num, got_a.dp, got_a.sel, got_a.sb, got_a.fd,
                   e.a.rdy, e.a.num, e.a.dp, e.a.sel, e.a.sb, e.a.fd);
        end
        checks++;
        if (got_b !== e.b) begin
          failures++;
          $display("FAIL scan_blank0 t=%0t got rdy=%b num=%h dp=%b sel=%b sb=%b fd=%b expected rdy=%b num=%h dp=%b sel=%b sb=%b fd=%b",
                   $time, got_b.rdy, got_b.num, got_b.dp, got_b.sel, got_b.sb, got_b.fd,
                   e.b.rdy, e.b.num, e.b.dp, e.b.sel, e.b.sb, e.b.fd);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_write(input logic [15:0] d, input logic [3:0] p);
    bit ok;
    ok = 1'b0;
    wr_data  = d;
    wr_dp    = p;
    wr_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rdy_a) begin
        @(posedge clk);
        #2;
        ok = 1'b1;
      end
    end
    wr_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL write_accept data=%h got wr_ready=0 for 200 cycles expected 1", d);
    end else begin
      $display("write data=%h dp=%b accepted t=%0t", d, p, $time);
    end
  endtask

  task automatic wait_frame_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (fd_a) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL frame_done_wait got no pulse in 100 cycles expected a pulse");
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [15:0] masks [4];
    masks[0] = 16'h000F; masks[1] = 16'h00FF; masks[2] = 16'h0FFF; masks[3] = 16'hFFFF;

    cyc(3);
    #1 rst_n = 1'b1;
    cyc(2);

    // Commit while dark, then scan 1234.
    do_write(16'h1234, 4'b0000);
    cyc(3);
    enable = 1'b1;
    cyc(60);

    // Mid-frame write waits for the boundary.
    cyc(7);
    do_write(16'hABCD, 4'b0010);
    cyc(60);

    // Leading-zero blanking.
    lz_blank = 1'b1;
    do_write(16'h0050, 4'b0000);
    cyc(50);
    do_write(16'h0000, 4'b0000);
    cyc(50);
    do_write(16'h0050, 4'b1000);
    cyc(50);
    lz_blank = 1'b0;

    // Drop enable at cycle 10 of a frame, then restart.
    wait_frame_done();
    cyc(10);
    enable = 1'b0;
    cyc(6);
    enable = 1'b1;
    cyc(40);

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      enable   = ($urandom_range(0, 3) != 0);
      lz_blank = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1)
        do_write($urandom() & masks[$urandom_range(0, 3)],
                 ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0);
      cyc($urandom_range(1, 40));
    end

    // Asynchronous reset during SHOW with a write pending.
    enable = 1'b1;
    lz_blank = 1'b0;
    cyc(30);
    do_write(16'h4321, 4'b0101);
    begin
      bit lit;
      lit = 1'b0;
      for (int i = 0; i < 50 && !lit; i++) begin
        @(negedge clk);
        if (sel_a != 4'h0) lit = 1'b1;
      end
      checks++;
      if (!lit) begin
        failures++;
        $display("FAIL show_wait got no lit digit in 50 cycles expected one");
      end
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (sel_a !== 4'h0 || sb_a !== 1'b1 || rdy_a !== 1'b1 || fd_a !== 1'b0 || num_a !== 4'h0 || dp_a !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got sel=%b sb=%b rdy=%b fd=%b num=%h dp=%b expected sel=0000 sb=1 rdy=1 fd=0 num=0 dp=0",
               sel_a, sb_a, rdy_a, fd_a, num_a, dp_a);
    end
    checks++;
    if (sel_b !== 4'h0 || sb_b !== 1'b1 || rdy_b !== 1'b1) begin
      failures++;
      $display("FAIL async_reset_b got sel=%b sb=%b rdy=%b expected sel=0000 sb=1 rdy=1", sel_b, sb_b, rdy_b);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
